// File: rtl/fp_div_pkg.sv
// Shared types, constants and operand unpacking for the binary32 divider.
package fp_div_pkg;

  localparam int unsigned BIAS   = 127;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned QBITS  = 27;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned E_W    = 10;
  localparam logic [31:0] QNAN   = 32'h7FC00000;

  // Unpacked operand: hidden bit restored, subnormals flushed to zero
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } operand_t;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_NAN,
    SP_INF,
    SP_ZERO
  } special_t;

  function automatic operand_t unpack(input logic [31:0] x);
    operand_t          o;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e         = x[FRAC_W +: EXP_W];
    f         = x[FRAC_W-1:0];
    o.sign    = x[31];
    o.exp     = e;
    o.is_zero = (e == '0);
    o.is_inf  = (&e) && (f == '0);
    o.is_nan  = (&e) && (f != '0);
    o.mant    = o.is_zero ? '0 : {1'b1, f};
    return o;
  endfunction

endpackage

// File: rtl/fp_div_core.sv
// Iterative restoring significand divider: one quotient bit per cycle.
module fp_div_core
  import fp_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] ma,
  input  logic [MANT_W-1:0] mb,
  output logic [QBITS-1:0]  quot,
  output logic              sticky,
  output logic              valid
);

  logic [MANT_W+1:0] rem;
  logic [MANT_W+1:0] diff;
  logic [MANT_W+1:0] rem_next;
  logic [MANT_W-1:0] dvsr;
  logic [CNT_W-1:0]  cnt;
  logic              run;
  logic              q_bit;

  // One restoring step: trial subtract, keep or restore, then shift
  always_comb begin
    diff     = rem - {2'b00, dvsr};
    q_bit    = (rem >= {2'b00, dvsr});
    rem_next = {rem[MANT_W:0], 1'b0};
    if (q_bit) begin
      rem_next = {diff[MANT_W:0], 1'b0};
    end
  end

  // Iteration registers; valid pulses once after the last quotient bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    <= '0;
      dvsr   <= '0;
      quot   <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      sticky <= 1'b0;
      valid  <= 1'b0;
    end else if (start) begin
      rem    <= {2'b00, ma};
      dvsr   <= mb;
      quot   <= '0;
      cnt    <= '0;
      run    <= 1'b1;
      sticky <= 1'b0;
      valid  <= 1'b0;
    end else if (run) begin
      rem    <= rem_next;
      quot   <= {quot[QBITS-2:0], q_bit};
      cnt    <= cnt + CNT_W'(1);
      sticky <= (rem_next != '0);
      if (cnt == CNT_W'(QBITS - 1)) begin
        run   <= 1'b0;
        valid <= 1'b1;
      end
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_division.sv
// Sequential binary32 divider: unpack, special cases, RNE rounding, FSM.
module fp_division
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S,
  output logic        overf,
  output logic        underf,
  output logic        busy,
  output logic        done
);

  state_t            state;
  state_t            next_state;
  operand_t          ua;
  operand_t          ub;
  special_t          special_c;
  special_t          special_r;
  logic              sign_r;
  logic signed [E_W-1:0] exp_c;
  logic signed [E_W-1:0] exp_r;
  logic              accept_c;

  logic [QBITS-1:0]  quot;
  logic              sticky;
  logic              core_valid;

  logic [QBITS-1:0]  qn_c;
  logic signed [E_W-1:0] e_norm_c;
  logic signed [E_W-1:0] e_fin_c;
  logic [MANT_W-1:0] mant_c;
  logic [MANT_W:0]   sum_c;
  logic              up_c;
  logic [FRAC_W-1:0] frac_c;
  logic [31:0]       result_c;
  logic              overf_c;
  logic              underf_c;

  // Operand unpack, special-case classification and biased exponent
  always_comb begin
    ua       = unpack(A);
    ub       = unpack(B);
    accept_c = (state == IDLE) && start;
    exp_c    = $signed({2'b00, ua.exp}) - $signed({2'b00, ub.exp})
             + $signed(E_W'(BIAS));
    if (ua.is_nan || ub.is_nan || (ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
      special_c = SP_NAN;
    end else if (ua.is_inf || ub.is_zero) begin
      special_c = SP_INF;
    end else if (ua.is_zero || ub.is_inf) begin
      special_c = SP_ZERO;
    end else begin
      special_c = SP_NONE;
    end
  end

  // Operation context captured at the accepted start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_r    <= 1'b0;
      exp_r     <= '0;
      special_r <= SP_NONE;
    end else if (accept_c) begin
      sign_r    <= ua.sign ^ ub.sign;
      exp_r     <= exp_c;
      special_r <= special_c;
    end
  end

  fp_div_core u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (accept_c),
    .ma     (ua.mant),
    .mb     (ub.mant),
    .quot   (quot),
    .sticky (sticky),
    .valid  (core_valid)
  );

  // Normalize, round to nearest even, range check and special override
  always_comb begin
    qn_c     = quot;
    e_norm_c = exp_r;
    if (!quot[QBITS-1]) begin
      qn_c     = {quot[QBITS-2:0], 1'b0};
      e_norm_c = exp_r - E_W'(1);
    end
    mant_c   = qn_c[QBITS-1:3];
    up_c     = qn_c[2] & (qn_c[1] | qn_c[0] | sticky | mant_c[0]);
    sum_c    = {1'b0, mant_c} + {{MANT_W{1'b0}}, up_c};
    e_fin_c  = e_norm_c;
    frac_c   = sum_c[FRAC_W-1:0];
    if (sum_c[MANT_W]) begin
      e_fin_c = e_norm_c + E_W'(1);
      frac_c  = '0;
    end
    overf_c  = 1'b0;
    underf_c = 1'b0;
    result_c = {sign_r, e_fin_c[EXP_W-1:0], frac_c};
    if (e_fin_c >= $signed(E_W'(255))) begin
      overf_c  = 1'b1;
      result_c = {sign_r, 8'hFF, 23'd0};
    end else if (e_fin_c <= $signed(E_W'(0))) begin
      underf_c = 1'b1;
      result_c = {sign_r, 31'd0};
    end
    case (special_r)
      SP_NAN: begin
        overf_c  = 1'b0;
        underf_c = 1'b0;
        result_c = QNAN;
      end
      SP_INF: begin
        overf_c  = 1'b0;
        underf_c = 1'b0;
        result_c = {sign_r, 8'hFF, 23'd0};
      end
      SP_ZERO: begin
        overf_c  = 1'b0;
        underf_c = 1'b0;
        result_c = {sign_r, 31'd0};
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = DIV;
      DIV:   if (core_valid) next_state = ROUND;
      ROUND: next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs; result and flags update only when leaving ROUND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S      <= '0;
      overf  <= 1'b0;
      underf <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (next_state == DIV) || (next_state == ROUND);
      done <= (next_state == DONE);
      if (state == ROUND) begin
        S      <= result_c;
        overf  <= overf_c;
        underf <= underf_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_division.sv
// Directed self-checking bench for fp_division.
module tb_fp_division;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] S;
  logic        overf;
  logic        underf;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  fp_division dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .S      (S),
    .overf  (overf),
    .underf (underf),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Launch one division, check latency, result, flags and the one-cycle done pulse
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_s, input logic exp_o, input logic exp_u);
    int cyc;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    check({tag, ".busy_after_start"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'd29);
    check({tag, ".S"}, S, exp_s);
    check({tag, ".overf"}, 32'(overf), 32'(exp_o));
    check({tag, ".underf"}, 32'(underf), 32'(exp_u));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".S_hold"}, S, exp_s);
  endtask

  initial begin
    int cyc;
    int pulses;
    int done_at;
    logic [31:0] s_cap;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    #1;
    check("reset.S", S, 32'd0);
    check("reset.overf", 32'(overf), 32'd0);
    check("reset.underf", 32'(underf), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_div("exact_418_2",   32'h43D10000, 32'h40000000, 32'h43510000, 1'b0, 1'b0);
    run_div("round_256_120", 32'h43800000, 32'h42F00000, 32'h40088889, 1'b0, 1'b0);
    run_div("half_eighth",   32'h3F000000, 32'h3E000000, 32'h40800000, 1'b0, 1'b0);
    run_div("norm_half_9",   32'h3F000000, 32'h41100000, 32'h3D638E39, 1'b0, 1'b0);
    run_div("zero_zero",     32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0);
    run_div("neg_by_inf",    32'hC0C00000, 32'h7F800000, 32'h80000000, 1'b0, 1'b0);
    run_div("overflow",      32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 1'b0);
    run_div("underflow",     32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b1);
    run_div("ovf_edge_255",  32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1, 1'b0);
    run_div("neg_by_zero",   32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b0);
    run_div("nan_in",        32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0);
    run_div("inf_inf",       32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0);
    run_div("subnormal_a",   32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);

    // start during the DONE cycle must be ignored
    @(negedge clk);
    A = 32'h3F800000;
    B = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("done_cycle.latency", 32'(cyc), 32'd29);
    check("done_cycle.S", S, 32'h3EAAAAAB);
    A = 32'h43D10000;
    B = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_cycle.busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("done_cycle.no_extra_done", 32'(pulses), 32'd0);
    check("done_cycle.S_hold", S, 32'h3EAAAAAB);

    // second start while busy is ignored
    @(negedge clk);
    A = 32'h3F000000;
    B = 32'h41100000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pulses  = 0;
    done_at = -1;
    s_cap   = '0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) begin
        A = 32'h43D10000;
        B = 32'h40000000;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (i == 5) start = 1'b0;
      if (done) begin
        pulses++;
        done_at = i;
        s_cap   = S;
      end
    end
    check("busy_start.pulses", 32'(pulses), 32'd1);
    check("busy_start.latency", 32'(done_at), 32'd29);
    check("busy_start.S", s_cap, 32'h3D638E39);

    // reset in the middle of DIV aborts the operation
    @(negedge clk);
    A = 32'h43D10000;
    B = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_reset.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_reset.S", S, 32'd0);
    check("mid_reset.busy", 32'(busy), 32'd0);
    check("mid_reset.done", 32'(done), 32'd0);
    check("mid_reset.overf", 32'(overf), 32'd0);
    check("mid_reset.underf", 32'(underf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("mid_reset.no_done", 32'(pulses), 32'd0);
    check("mid_reset.S_after", S, 32'd0);

    run_div("after_reset", 32'h3F000000, 32'h3E000000, 32'h40800000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
